// File: rtl/ps2_rx_io.sv
// PS/2 keyboard receiver on the io bus.
// Deserialises frames into a byte FIFO behind DATA/STATUS/CTRL registers.
module ps2_rx_io #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
  parameter int          FIFO_DEPTH     = 8,
  parameter int          TIMEOUT_CYCLES = 5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic [31:0] addr,
  input  logic        wEn,
  input  logic        rEn,
  input  logic [31:0] dataIn,
  output logic [31:0] dataOut,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]    ck_sync;
  logic [1:0]    dt_sync;
  logic          ck_d;
  logic          fe;
  logic          din;

  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout;
  logic          stop_ev;
  logic          par_ok;
  logic          push;

  logic          enable;
  logic          irq_en;
  logic          ovf;
  logic          perr;
  logic          ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          pop;
  logic          push_ok;
  logic          flush;
  logic          ovf_set;

  logic          sel;
  logic [1:0]    off;
  logic          wr_stat;
  logic          wr_ctrl;
  logic [3:0]    cnt4;
  logic [7:0]    rd_byte;
  logic          unused;

  assign unused = ^{addr[1:0], dataIn[31:5]};

  // Two-flop synchronisers plus a delayed copy for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ck_sync <= 2'b11;
      dt_sync <= 2'b11;
      ck_d    <= 1'b1;
    end else begin
      ck_sync <= {ck_sync[0], ps2_clk};
      dt_sync <= {dt_sync[0], ps2_data};
      ck_d    <= ck_sync[1];
    end
  end

  assign fe  = ck_d & ~ck_sync[1];
  assign din = dt_sync[1];

  assign timeout = enable & ~fe & (state != S_IDLE)
                 & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign stop_ev = enable & fe & (state == S_STOP);
  assign par_ok  = ^{shreg, par_bit};
  assign push    = stop_ev & par_ok & din;

  // Frame receiver, advanced on synced ps2_clk falling edges.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bitcnt  <= '0;
      par_bit <= 1'b0;
      tcnt    <= '0;
    end else if (!enable) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else if (fe) begin
      tcnt <= '0;
      case (state)
        S_IDLE: begin
          if (!din) begin
            state  <= S_DATA;
            bitcnt <= '0;
          end
        end
        S_DATA: begin
          shreg  <= {din, shreg[7:1]};
          bitcnt <= bitcnt + 3'd1;
          if (bitcnt == 3'd7) state <= S_PAR;
        end
        S_PAR: begin
          par_bit <= din;
          state   <= S_STOP;
        end
        default: state <= S_IDLE;
      endcase
    end else if (state == S_IDLE || timeout) begin
      state <= S_IDLE;
      tcnt  <= '0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  assign sel     = addr[31:4] == BASE_ADDR[31:4];
  assign off     = addr[3:2];
  assign wr_stat = sel & wEn & (off == 2'd1);
  assign wr_ctrl = sel & wEn & (off == 2'd2);
  assign flush   = wr_ctrl & dataIn[2];

  assign empty   = count == '0;
  assign full    = count == (AW+1)'(FIFO_DEPTH);
  assign pop     = sel & rEn & (off == 2'd0) & ~empty & ~flush;
  assign push_ok = push & (~full | pop) & ~flush;
  assign ovf_set = push & full & ~pop & ~flush;

  // Byte storage, written at the tail.
  always_ff @(posedge clock) begin
    if (push_ok) mem[tail] <= shreg;
  end

  // FIFO pointers and occupancy; flush overrides everything.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push_ok) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      if (push_ok && !pop) count <= count + (AW+1)'(1);
      else if (pop && !push_ok) count <= count - (AW+1)'(1);
    end
  end

  // Control bits and sticky flags; a set event beats a W1C.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable <= 1'b1;
      irq_en <= 1'b0;
      ovf    <= 1'b0;
      perr   <= 1'b0;
      ferr   <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= dataIn[0];
        irq_en <= dataIn[1];
      end
      ovf  <= ovf_set | (ovf & ~(wr_stat & dataIn[2]));
      perr <= (stop_ev & ~par_ok)
            | (perr & ~(wr_stat & dataIn[3]));
      ferr <= (stop_ev & par_ok & ~din) | timeout
            | (ferr & ~(wr_stat & dataIn[4]));
    end
  end

  // Level interrupt, registered from the current flag state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) irq <= 1'b0;
    else irq <= irq_en & (~empty | ovf | perr | ferr);
  end

  assign cnt4    = 4'(count);
  assign rd_byte = empty ? 8'h00 : mem[head];

  // Combinational register read mux.
  always_comb begin
    dataOut = '0;
    if (sel) begin
      case (off)
        2'd0: dataOut = {24'b0, rd_byte};
        2'd1: dataOut = {20'b0, cnt4, 3'b0,
                         ferr, perr, ovf, full, ~empty};
        2'd2: dataOut = {30'b0, irq_en, enable};
        default: dataOut = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_io.sv
// Directed bench for ps2_rx_io.
// PS/2 bit period 20 us, system clock 1 MHz.
`timescale 1ns/1ps
module tb_ps2_rx_io;

  localparam logic [31:0] A_DATA = 32'h0000_1000;
  localparam logic [31:0] A_STAT = 32'h0000_1004;
  localparam logic [31:0] A_CTRL = 32'h0000_1008;
  localparam logic [31:0] A_RSV  = 32'h0000_100C;
  localparam logic [31:0] A_OUT  = 32'h0000_2000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] addr = '0;
  logic        wEn = 1'b0;
  logic        rEn = 1'b0;
  logic [31:0] dataIn = '0;
  logic [31:0] dataOut;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] d;

  always #500 clock = ~clock;

  ps2_rx_io dut (
    .clock    (clock),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .addr     (addr),
    .wEn      (wEn),
    .rEn      (rEn),
    .dataIn   (dataIn),
    .dataOut  (dataOut),
    .irq      (irq)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] b);
    return ~^b;
  endfunction

  task automatic rd(input logic [31:0] a, input logic p,
                    output logic [31:0] v);
    @(negedge clock);
    addr = a;
    rEn = p;
    #1 v = dataOut;
    @(negedge clock);
    rEn = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] v);
    @(negedge clock);
    addr = a;
    dataIn = v;
    wEn = 1'b1;
    @(negedge clock);
    wEn = 1'b0;
    dataIn = '0;
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = bits[i];
      #10000 ps2_clk = 1'b0;
      #10000 ps2_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic par,
                           input logic stop);
    send_bits({stop, par, b, 1'b0}, 11);
    ps2_data = 1'b1;
    #10000;
  endtask

  initial begin
    repeat (3) @(negedge clock);
    addr = A_STAT;
    #1 chk("rst_status", dataOut, 32'h0);
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    rd(A_CTRL, 1'b0, d); chk("ctrl_reset", d, 32'h1);
    rd(A_DATA, 1'b1, d); chk("data_empty", d, 32'h0);
    rd(A_RSV, 1'b0, d);  chk("reserved", d, 32'h0);

    send_byte(8'h1C, 1'b0, 1'b1);
    rd(A_STAT, 1'b0, d); chk("st_1c", d, 32'h101);
    rd(A_OUT, 1'b1, d);  chk("unsel_rd", d, 32'h0);
    rd(A_STAT, 1'b0, d); chk("unsel_nopop", d, 32'h101);
    rd(A_DATA, 1'b1, d); chk("data_1c", d, 32'h1C);
    rd(A_STAT, 1'b0, d); chk("st_after_pop", d, 32'h0);
    chk("irq_disabled", 32'(irq), 32'h0);

    send_byte(8'hF0, 1'b0, 1'b1);
    rd(A_STAT, 1'b0, d); chk("st_perr", d, 32'h008);
    wr(A_STAT, 32'h08);
    rd(A_STAT, 1'b0, d); chk("st_perr_clr", d, 32'h0);

    for (int b = 1; b <= 9; b++)
      send_byte(8'(b), odd_par(8'(b)), 1'b1);
    rd(A_STAT, 1'b0, d); chk("st_ovf", d, 32'h807);
    for (int b = 1; b <= 8; b++) begin
      rd(A_DATA, 1'b1, d);
      chk($sformatf("ovf_rd%0d", b), d, 32'(b));
    end
    rd(A_STAT, 1'b0, d); chk("st_ovf_drain", d, 32'h004);

    wr(A_STAT, 32'h1C);
    for (int b = 8'h11; b <= 8'h18; b++)
      send_byte(8'(b), odd_par(8'(b)), 1'b1);
    rd(A_STAT, 1'b0, d); chk("st_full", d, 32'h803);
    send_bits({odd_par(8'h55), 8'h55, 1'b0}, 10);
    ps2_data = 1'b1;
    #10000 ps2_clk = 1'b0;
    #2000;
    addr = A_DATA;
    rEn = 1'b1;
    #1 d = dataOut;
    #999 rEn = 1'b0;
    #7000 ps2_clk = 1'b1;
    #10000;
    chk("aligned_pop", d, 32'h11);
    rd(A_STAT, 1'b0, d); chk("st_aligned", d, 32'h803);
    for (int b = 8'h12; b <= 8'h18; b++) begin
      rd(A_DATA, 1'b1, d);
      chk($sformatf("full_rd%0h", b), d, 32'(b));
    end
    rd(A_DATA, 1'b1, d); chk("last_55", d, 32'h55);
    rd(A_STAT, 1'b0, d); chk("st_empty", d, 32'h0);

    send_bits(11'h00A, 4);
    ps2_data = 1'b1;
    repeat (4900) @(negedge clock);
    rd(A_STAT, 1'b0, d); chk("to_before", d, 32'h0);
    repeat (200) @(negedge clock);
    rd(A_STAT, 1'b0, d); chk("to_ferr", d, 32'h010);
    send_byte(8'h2A, 1'b0, 1'b1);
    rd(A_STAT, 1'b0, d); chk("st_2a", d, 32'h111);
    rd(A_DATA, 1'b1, d); chk("data_2a", d, 32'h2A);
    wr(A_STAT, 32'h10);

    send_byte(8'h3C, 1'b1, 1'b0);
    rd(A_STAT, 1'b0, d); chk("st_stop_err", d, 32'h010);
    wr(A_STAT, 32'h10);

    send_byte(8'h33, 1'b1, 1'b1);
    wr(A_CTRL, 32'h5);
    rd(A_STAT, 1'b0, d); chk("st_flush", d, 32'h0);
    rd(A_CTRL, 1'b0, d); chk("ctrl_rd", d, 32'h1);

    wr(A_CTRL, 32'h3);
    send_byte(8'h1C, 1'b0, 1'b1);
    @(negedge clock);
    chk("irq_set", 32'(irq), 32'h1);
    send_bits(11'h006, 3);
    @(negedge clock);
    reset = 1'b0;
    addr = A_STAT;
    #1 chk("rst_mid_st", dataOut, 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    rd(A_CTRL, 1'b0, d); chk("ctrl_after_rst", d, 32'h1);
    send_byte(8'h1C, 1'b0, 1'b1);
    rd(A_STAT, 1'b0, d); chk("st_1c_post", d, 32'h101);
    rd(A_DATA, 1'b1, d); chk("data_1c_post", d, 32'h1C);
    chk("irq_post", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
